// File: rtl/fb_draw_controller.sv
// Framebuffer draw sequencer: CPU-loaded registers launch PLOT/FILL pixel streams.
// Optional full-screen CLEAR command is built when FB_CLEAR_CMD_EN is defined.
module fb_draw_controller #(
  parameter int unsigned RES_W = 200,
  parameter int unsigned RES_H = 150
) (
  input  logic       PIXEL_CLOCK,
  input  logic       RESET_N,
  input  logic [2:0] REG_ADDR,
  input  logic [7:0] REG_WDATA,
  input  logic       REG_WE,
  output logic [7:0] REG_RDATA,
  output logic       BUSY,
  output logic [7:0] X_POS,
  output logic [7:0] Y_POS,
  output logic [2:0] COLOR,
  output logic       WRITE
);

  localparam logic [7:0] XMax = 8'(RES_W - 1);
  localparam logic [7:0] YMax = 8'(RES_H - 1);

  typedef enum logic [1:0] {StIdle, StPlot, StFill} state_e;

  state_e     state_q, state_d;
  logic [7:0] x0_q, y0_q, x1_q, y1_q, cmd_q;
  logic [2:0] color_q;
  logic       overrun_q;
  logic [7:0] xs_q, xe_q, ye_q, xs_d, xe_d, ye_d;
  logic [7:0] x_pos_q, y_pos_q, x_pos_d, y_pos_d;
  logic [2:0] color_out_q, color_out_d;
  logic       write_q, write_d, busy_q, busy_d;

  logic       reg_wr_cmd, cmd_accept, launch_plot, launch_fill, cmd_clear;
  logic       plot_valid, fill_nonempty, last_px;
  logic [7:0] sx, sy, ex, ey;

  assign reg_wr_cmd  = REG_WE && (REG_ADDR == 3'd5);
  assign cmd_accept  = reg_wr_cmd && (state_q == StIdle);
`ifdef FB_CLEAR_CMD_EN
  assign cmd_clear   = (REG_WDATA[1:0] == 2'd2);
`else
  assign cmd_clear   = 1'b0;
`endif
  assign launch_plot = cmd_accept && (REG_WDATA[1:0] == 2'd0);
  assign launch_fill = cmd_accept && ((REG_WDATA[1:0] == 2'd1) || cmd_clear);
  assign plot_valid  = (x0_q <= XMax) && (y0_q <= YMax);
  assign last_px     = (x_pos_q == xe_q) && (y_pos_q == ye_q);

  // Launch geometry: clipped to the framebuffer so counters never need to wrap.
  always_comb begin
    sx = x0_q;
    sy = y0_q;
    ex = (x1_q > XMax) ? XMax : x1_q;
    ey = (y1_q > YMax) ? YMax : y1_q;
    if (cmd_clear) begin
      sx = 8'd0;
      sy = 8'd0;
      ex = XMax;
      ey = YMax;
    end
    fill_nonempty = (sx <= ex) && (sy <= ey);
  end

  // Register file and sticky overrun flag
  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      x0_q      <= 8'd0;
      y0_q      <= 8'd0;
      x1_q      <= 8'd0;
      y1_q      <= 8'd0;
      cmd_q     <= 8'd0;
      color_q   <= 3'd0;
      overrun_q <= 1'b0;
    end else if (REG_WE) begin
      case (REG_ADDR)
        3'd0: x0_q    <= REG_WDATA;
        3'd1: y0_q    <= REG_WDATA;
        3'd2: x1_q    <= REG_WDATA;
        3'd3: y1_q    <= REG_WDATA;
        3'd4: color_q <= REG_WDATA[2:0];
        3'd5: begin
          cmd_q <= REG_WDATA;
          if (state_q != StIdle) overrun_q <= 1'b1;
        end
        3'd6: overrun_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (REG_ADDR)
      3'd0:    REG_RDATA = x0_q;
      3'd1:    REG_RDATA = y0_q;
      3'd2:    REG_RDATA = x1_q;
      3'd3:    REG_RDATA = y1_q;
      3'd4:    REG_RDATA = {5'd0, color_q};
      3'd5:    REG_RDATA = cmd_q;
      3'd6:    REG_RDATA = {6'd0, overrun_q, busy_q};
      default: REG_RDATA = 8'd0;
    endcase
  end

  // FSM state register
  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next state; an empty FILL spends exactly one cycle in StFill.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (launch_plot)      state_d = StPlot;
        else if (launch_fill) state_d = StFill;
      end
      StPlot:  state_d = StIdle;
      StFill:  if (!write_q || last_px) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: next values of the registered pixel stream and working rectangle
  always_comb begin
    write_d     = 1'b0;
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    color_out_d = color_out_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ye_d        = ye_q;
    unique case (state_q)
      StIdle: begin
        if (launch_plot && plot_valid) begin
          write_d     = 1'b1;
          x_pos_d     = x0_q;
          y_pos_d     = y0_q;
          color_out_d = color_q;
        end else if (launch_fill) begin
          xs_d = sx;
          xe_d = ex;
          ye_d = ey;
          if (fill_nonempty) begin
            write_d     = 1'b1;
            x_pos_d     = sx;
            y_pos_d     = sy;
            color_out_d = color_q;
          end
        end
      end
      StFill: begin
        if (write_q && !last_px) begin
          write_d = 1'b1;
          if (x_pos_q == xe_q) begin
            x_pos_d = xs_q;
            y_pos_d = y_pos_q + 8'd1;
          end else begin
            x_pos_d = x_pos_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      x_pos_q     <= 8'd0;
      y_pos_q     <= 8'd0;
      color_out_q <= 3'd0;
      xs_q        <= 8'd0;
      xe_q        <= 8'd0;
      ye_q        <= 8'd0;
    end else begin
      write_q     <= write_d;
      busy_q      <= busy_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      color_out_q <= color_out_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
    end
  end

  assign WRITE = write_q;
  assign BUSY  = busy_q;
  assign X_POS = x_pos_q;
  assign Y_POS = y_pos_q;
  assign COLOR = color_out_q;

endmodule
